// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder for the RiSC16 fetch path
//
// Memory-side end of the fetch interface. A request accepted in IDLE returns the
// addressed word after WAIT_CYCLES wait states with a one-cycle ready pulse.
// A write-only load port fills the memory in any state.
//
// Optional feature macro: IMEM_PREFETCH_EN (one-entry next-word prefetch buffer).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req        in   fetch request, held with stable addr until ready
//   addr       in   byte address (PC), bit 0 must be 0
//   rdata      out  instruction word, valid while ready=1, otherwise 0
//   ready      out  one-cycle response pulse
//   fault      out  misaligned / out-of-range fetch, valid with ready
//   busy       out  high whenever the FSM is not IDLE
//   load_en    in   load-port write strobe
//   load_addr  in   load-port byte address
//   load_data  in   load-port write data
module imem_responder #(
  parameter int WORD_LEN    = 16,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [WORD_LEN-1:0] addr,
  output logic [WORD_LEN-1:0] rdata,
  output logic                ready,
  output logic                fault,
  output logic                busy,
  input  logic                load_en,
  input  logic [WORD_LEN-1:0] load_addr,
  input  logic [WORD_LEN-1:0] load_data
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WORD_LEN-1:0] lat_addr_q, lat_addr_d;
  logic                mem_fire;   // registering edge of a memory-sourced response
  logic                bypass;     // registering edge of a buffer-sourced response
  logic [WORD_LEN-1:0] resp_addr;
  logic                pf_hit;
  logic [WORD_LEN-1:0] pf_data;

  logic [WORD_LEN-1:0] mem [DEPTH];

  // Misaligned, or any bit above the word index set.
  function automatic logic addr_bad(input logic [WORD_LEN-1:0] a);
    return a[0] | ((a >> (DEPTH_LOG2 + 1)) != '0);
  endfunction

  // With WAIT_CYCLES=0 the response is registered on the accepting edge, so the
  // live addr is used; otherwise the address latched at acceptance.
  assign resp_addr = (state_q == S_IDLE) ? addr : lat_addr_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    mem_fire   = 1'b0;
    bypass     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          lat_addr_d = addr;
          if (pf_hit) begin
            state_d = S_RESP;
            bypass  = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            mem_fire = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d  = S_RESP;
          cnt_d    = 4'd0;
          mem_fire = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      lat_addr_q <= '0;
      rdata      <= '0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      if (mem_fire) begin
        // Reads the pre-write contents if the load port hits the same word now.
        fault <= addr_bad(resp_addr);
        rdata <= addr_bad(resp_addr) ? '0 : mem[resp_addr[DEPTH_LOG2:1]];
      end else if (bypass) begin
        fault <= 1'b0;
        rdata <= pf_data;
      end else begin
        fault <= 1'b0;
        rdata <= '0;
      end
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_en && !addr_bad(load_addr)) begin
      mem[load_addr[DEPTH_LOG2:1]] <= load_data;
    end
  end

  assign ready = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);

`ifdef IMEM_PREFETCH_EN
  logic                pf_valid_q;
  logic [WORD_LEN-1:0] pf_addr_q;
  logic [WORD_LEN-1:0] pf_data_q;
  logic [WORD_LEN-1:0] next_addr;
  logic                load_ok;

  assign next_addr = resp_addr + WORD_LEN'(2);
  assign load_ok   = load_en && !addr_bad(load_addr);
  assign pf_hit    = pf_valid_q && (addr == pf_addr_q);
  assign pf_data   = pf_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
    end else if ((mem_fire && !addr_bad(resp_addr)) || bypass) begin
      // Refill with the following word; a same-edge load to that word would
      // leave the buffer stale, so it starts out invalid in that case.
      pf_addr_q  <= next_addr;
      pf_data_q  <= mem[next_addr[DEPTH_LOG2:1]];
      pf_valid_q <= !addr_bad(next_addr) &&
                    !(load_ok && (load_addr[DEPTH_LOG2:1] == next_addr[DEPTH_LOG2:1]));
    end else if (load_ok && (load_addr[DEPTH_LOG2:1] == pf_addr_q[DEPTH_LOG2:1])) begin
      pf_valid_q <= 1'b0;
    end
  end
`else
  assign pf_hit  = 1'b0;
  assign pf_data = '0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;

  localparam int WC = 2;
`ifdef IMEM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [15:0] addr;
  logic [15:0] rdata;
  logic        ready;
  logic        fault;
  logic        busy;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  always #5 clk = ~clk;

  imem_responder #(.WORD_LEN(16), .DEPTH_LOG2(8), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .rdata(rdata),
    .ready(ready), .fault(fault), .busy(busy), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: word array plus the word index the prefetch buffer holds.
  logic [15:0] model_mem [256];
  bit          pf_valid = 1'b0;
  int          pf_word  = 0;

  function automatic bit model_fault(input logic [15:0] a);
    int ai;
    ai = int'(a);
    return ((ai % 2) != 0) || ((ai / 2) >= 256);
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    return PF && pf_valid && !model_fault(a) && (pf_word == int'(a) / 2);
  endfunction

  function automatic void model_respond(input logic [15:0] a);
    if (PF && !model_fault(a)) begin
      pf_word  = int'(a) / 2 + 1;
      pf_valid = (pf_word < 256);
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    if (!model_fault(a)) begin
      model_mem[int'(a) / 2] = d;
      if (pf_valid && pf_word == int'(a) / 2) pf_valid = 1'b0;
    end
  endtask

  task automatic fetch(input logic [15:0] a, output int lat);
    logic [15:0] exp_d;
    logic        exp_f;
    int          exp_lat;
    int          busy_cnt;
    exp_f   = model_fault(a);
    exp_d   = 16'h0000;
    if (!exp_f) exp_d = model_mem[int'(a) / 2];
    exp_lat = model_hit(a) ? 1 : WC + 1;
    req = 1'b1; addr = a; lat = 0; busy_cnt = 0;
    do begin
      tick();
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end while (ready !== 1'b1 && lat < 20);
    req = 1'b0;
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_timeout addr=%h ready=%b required=1", a, ready);
    end
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL fetch_latency addr=%h got=%0d required=%0d", a, lat, exp_lat);
    end
    tests_run++;
    if (rdata !== exp_d || fault !== exp_f) begin
      tests_failed++;
      $display("FAIL fetch_data addr=%h got=%h/%b required=%h/%b", a, rdata, fault, exp_d, exp_f);
    end
    tests_run++;
    if (busy_cnt !== exp_lat) begin
      tests_failed++;
      $display("FAIL fetch_busy addr=%h got=%0d required=%0d", a, busy_cnt, exp_lat);
    end
    model_respond(a);
    tick();
    tests_run++;
    if ({ready, busy, fault, rdata} !== 19'd0) begin
      tests_failed++;
      $display("FAIL fetch_after addr=%h got r%b b%b f%b d%h required all 0", a, ready, busy, fault, rdata);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #2;
    tests_run++;
    if ({ready, busy, fault, rdata} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got r%b b%b f%b d%h required all 0", ready, busy, fault, rdata);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({ready, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_idle got r%b b%b required 00", ready, busy);
    end
    for (int i = 0; i < 256; i++) do_load(16'(i * 2), 16'($urandom));
  endtask

  task automatic test_basic;
    int lat;
    do_load(16'h0000, 16'h1234);
    fetch(16'h0000, lat);
  endtask

  task automatic test_fault;
    int lat;
    fetch(16'h0003, lat);
    fetch(16'h0200, lat);
    fetch(16'hFFFE, lat);
    fetch(16'h01FF, lat);
    fetch(16'h01FE, lat);
  endtask

  task automatic test_back_to_back;
    int  n;
    int  m;
    int  exp_gap;
    int  extra;
    do_load(16'h0000, 16'hAAAA);
    do_load(16'h0002, 16'h5555);
    req = 1'b1; addr = 16'h0000; n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 20);
    tests_run++;
    if (ready !== 1'b1 || rdata !== model_mem[0]) begin
      tests_failed++;
      $display("FAIL b2b_first got r%b d%h required 1/%h", ready, rdata, model_mem[0]);
    end
    model_respond(16'h0000);
    exp_gap = model_hit(16'h0002) ? 2 : WC + 2;
    addr = 16'h0002; m = 0;
    do begin tick(); m++; end while (ready !== 1'b1 && m < 20);
    req = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || m !== exp_gap || rdata !== model_mem[1]) begin
      tests_failed++;
      $display("FAIL b2b_second got r%b gap=%0d d%h required 1 gap=%0d d%h", ready, m, rdata, exp_gap, model_mem[1]);
    end
    model_respond(16'h0002);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ready === 1'b1) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL b2b_duplicate got %0d extra pulses required 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int pulses;
    int lat;
    req = 1'b1; addr = 16'h0004;
    tick(); tick();
    #3;
    reset = 1'b1; req = 1'b0;
    #1;
    pf_valid = 1'b0;
    tests_run++;
    if ({ready, busy, fault, rdata} !== 19'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs got r%b b%b f%b d%h required all 0", ready, busy, fault, rdata);
    end
    pulses = 0;
    tick();
    if (ready === 1'b1) pulses++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL abort_pulse got %0d pulses required 0", pulses);
    end
    fetch(16'h0004, lat);
  endtask

  task automatic test_read_before_write;
    int lat;
    do_load(16'h0010, 16'h1111);
    req = 1'b1; addr = 16'h0010;
    repeat (WC) tick();
    load_en = 1'b1; load_addr = 16'h0010; load_data = 16'hBEEF;
    tick();
    load_en = 1'b0; req = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || rdata !== 16'h1111 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL rbw_old got r%b d%h f%b required 1/1111/0", ready, rdata, fault);
    end
    model_respond(16'h0010);
    model_mem[8] = 16'hBEEF;
    tick();
    fetch(16'h0010, lat);
  endtask

  task automatic test_random;
    int          lat;
    logic [15:0] a;
    logic [15:0] last;
    last = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1: do_load(16'($urandom_range(0, 255) * 2), 16'($urandom));
        2:    do_load(16'($urandom), 16'($urandom));
        3:    begin a = 16'($urandom); fetch(a, lat); last = a; end
        4, 5: begin a = last + 16'd2; fetch(a, lat); last = a; end
        default: begin a = 16'($urandom_range(0, 255) * 2); fetch(a, lat); last = a; end
      endcase
    end
  endtask

`ifdef IMEM_PREFETCH_EN
  task automatic test_prefetch;
    int lat;
    fetch(16'h0004, lat);
    fetch(16'h0006, lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL pf_hit_latency got=%0d required=1", lat);
    end
    fetch(16'h0008, lat);
    do_load(16'h000A, 16'h000A);
    fetch(16'h000A, lat);
    tests_run++;
    if (lat !== WC + 1) begin
      tests_failed++;
      $display("FAIL pf_invalidate_latency got=%0d required=%0d", lat, WC + 1);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_back_to_back();
    test_reset_abort();
    test_read_before_write();
`ifdef IMEM_PREFETCH_EN
    test_prefetch();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder for the RiSC16 fetch path; the memory-side end of the fetch interface.
- Fetch stage presents a byte-addressed PC with a request; this block returns the 16-bit instruction word after a configurable number of wait states, with a one-cycle ready pulse.
- Also provides a write-only load port so the testbench or boot logic can place programs in memory.

Parameters:
- WORD_LEN, 16, instruction/data word width in bits.
- DEPTH_LOG2, 8, log2 of memory depth in words (default 256 words, byte addresses 0x0000-0x01FE).
- WAIT_CYCLES, 2, wait states inserted between request acceptance and the response (0-15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  fetch request; held high with stable addr until ready is seen.
- addr  in  WORD_LEN  byte address (PC); bit 0 must be 0.
- rdata  out  WORD_LEN  instruction word; valid only while ready=1.
- ready  out  1  one-cycle response pulse.
- fault  out  1  valid with ready; misaligned or out-of-range fetch.
- busy  out  1  high whenever state is not IDLE.
- load_en  in  1  write strobe for the load port.
- load_addr  in  WORD_LEN  byte address for the load write.
- load_data  in  WORD_LEN  word to write.

Behaviour:
- Reset (async, active-high): state goes to IDLE; rdata=0, ready=0, fault=0, busy=0, wait counter=0. Memory contents are not reset. A reset during WAIT or RESP aborts the transaction with no ready pulse.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with req=1, latch addr and move to WAIT with counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0, move directly to RESP.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, the next edge moves to RESP and registers rdata/fault from the latched address.
- RESP:
  - ready=1 for exactly one cycle; then return to IDLE.
  - req is ignored in RESP. A new request is sampled only in IDLE.
- Latency: req sampled at edge 0 -> ready high in cycle WAIT_CYCLES+1. Back-to-back throughput is one fetch per WAIT_CYCLES+2 cycles.
- addr is latched at acceptance; changes to addr during WAIT are ignored.
- If req drops during WAIT, the transaction still completes and ready still pulses.
- Fault conditions:
  - Fault if latched addr[0]=1, or addr[WORD_LEN-1:DEPTH_LOG2+1] is nonzero.
  - On fault: rdata=0 (NOP encoding) and fault=1.
  - Otherwise rdata=mem[addr[DEPTH_LOG2:1]] and fault=0.
- rdata and fault return to 0 in the cycle after RESP.
- Load port:
  - When load_en=1 on a clk edge, write load_data to mem[load_addr[DEPTH_LOG2:1]]. Writes are accepted in any FSM state.
  - Writes to misaligned or out-of-range load_addr are silently dropped.
  - Read-before-write: a load to the same word on the same edge that registers rdata returns the old contents.

Optional Feature:
- Macro: IMEM_PREFETCH_EN.
- When defined:
  - After every non-faulting response for address A, the block reads A+2 into a one-entry prefetch buffer and marks it valid. If A+2 is out of range, the buffer is marked invalid.
  - In IDLE, a req whose addr equals the buffered address bypasses WAIT: next state is RESP, with ready at cycle 1 and rdata taken from the buffer.
  - Any load_en write to the buffered word invalidates the buffer.
  - Reset invalidates the buffer.
- When undefined: no buffer exists, and every fetch takes WAIT_CYCLES+1 cycles.

Test Plan:
- Load 0x1234 at byte address 0x0000, reset released, req with addr=0x0000 -> ready high exactly 3 cycles after the sampled req (WAIT_CYCLES=2), rdata=0x1234, fault=0, busy high for 3 cycles.
- req with addr=0x0003 -> ready after 3 cycles, rdata=0x0000, fault=1. Repeat with addr=0x0200 -> same result (out of range).
- Hold req high continuously with addr=0x0000, then 0x0002 (contents 0xAAAA, 0x5555) -> ready pulses 4 cycles apart returning 0xAAAA then 0x5555; no duplicate response for the held req.
- Assert reset in the second WAIT cycle -> no ready pulse, all outputs 0 immediately (async), and the next req completes normally.
- Load 0xBEEF to 0x0010 on the same edge that registers the read of 0x0010 (old value 0x1111) -> rdata=0x1111; the following fetch of 0x0010 returns 0xBEEF.
- With IMEM_PREFETCH_EN: fetch 0x0004, then 0x0006 -> second ready arrives 1 cycle after the sampled req. Fetch 0x0008, write 0x0A to location 0x000A, then fetch 0x000A -> full 3-cycle latency and the newly written data is returned.
